// File: rtl/pmodals_spi_responder.sv
// PmodALS (ADC081S021-style) SPI responder.
// Answers an SPI master's CS/SCK with a FRAME_LEN-bit MISO frame that carries
// a DATA_W-bit sample padded with leading and trailing zeros, MSB first.
// CS and SCK are oversampled in the clk_pi domain; nothing here is clocked by SCK.
module pmodals_spi_responder #(
    parameter int DATA_W      = 8,
    parameter int LEAD_ZEROS  = 4,
    parameter int FRAME_LEN   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_pi,
    input  logic              rst_n_pi,
    input  logic [DATA_W-1:0] sample_pi,
    input  logic              sample_valid_pi,
    input  logic              sck_pi,
    input  logic              cs_pi,
    output logic              miso_po,
    output logic              busy_po,
    output logic              frame_done_po,
    output logic              abort_po,
    output logic [15:0]       frame_cnt_po
);

    localparam int TRAIL_ZEROS = FRAME_LEN - LEAD_ZEROS - DATA_W;
    localparam int CNT_W       = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        FINISH
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sck_prev_q;
    logic                   cs_prev_q;
    logic                   sck_s, cs_s;
    logic                   sck_fall, sck_rise, cs_fall, cs_rise;

    logic [DATA_W-1:0]    hold_q;
    logic [DATA_W-1:0]    load_data;
    logic [FRAME_LEN-1:0] frame_word;
    logic [FRAME_LEN-1:0] shift_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [CNT_W-1:0]     rise_cnt_q;
    logic                 frame_ok;
    logic                 miso_q;
    logic                 abort_q;
    logic [15:0]          frame_cnt_q;

    // Synchronize SCK/CS into clk_pi and keep one delayed copy for edge detection.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            sck_sync_q <= '0;
            cs_sync_q  <= '1;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_pi};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_pi};
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
            cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_fall = sck_prev_q & ~sck_s;
    assign sck_rise = ~sck_prev_q & sck_s;
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;

    // Holding register: takes a new sample on any cycle; an active frame keeps its own copy.
    // NOTE: the holding register is reset because a frame after reset must report 0x00.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            hold_q <= '0;
        end else if (sample_valid_pi) begin
            hold_q <= sample_pi;
        end
    end

    // A sample presented in the LOAD cycle itself bypasses the holding register.
    assign load_data  = sample_valid_pi ? sample_pi : hold_q;
    assign frame_word = FRAME_LEN'(load_data) << TRAIL_ZEROS;

    // A frame is complete only when every bit was shifted and the master clocked them all in.
    assign frame_ok = (bit_cnt_q == FULL_CNT) && (rise_cnt_q == FULL_CNT);

    // State register.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: state_d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cs_fall) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = frame_ok ? FINISH : IDLE;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame datapath: shift register, bit/rise counters, MISO, abort pulse and frame counter.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rise_cnt_q  <= '0;
            miso_q      <= 1'b0;
            abort_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            abort_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                end
                LOAD: begin
                    shift_q    <= frame_word;
                    miso_q     <= frame_word[FRAME_LEN-1];
                    bit_cnt_q  <= CNT_W'(1);
                    rise_cnt_q <= '0;
                end
                SHIFT: begin
                    if (cs_rise) begin
                        miso_q  <= 1'b0;
                        abort_q <= ~frame_ok;
                    end else begin
                        if (sck_fall) begin
                            if (bit_cnt_q != FULL_CNT) begin
                                shift_q   <= {shift_q[FRAME_LEN-2:0], 1'b0};
                                miso_q    <= shift_q[FRAME_LEN-2];
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end else begin
                                miso_q <= 1'b0;
                            end
                        end
                        if (sck_rise && (rise_cnt_q != FULL_CNT)) begin
                            rise_cnt_q <= rise_cnt_q + CNT_W'(1);
                        end
                    end
                end
                FINISH: begin
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign miso_po       = miso_q;
    assign busy_po       = (state_q != IDLE);
    assign frame_done_po = (state_q == FINISH);
    assign abort_po      = abort_q;
    assign frame_cnt_po  = frame_cnt_q;

endmodule
